// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared types and constants for the digit-serial packed-BCD adder.
// Optional invalid-digit checking is enabled with the BCD_ERR_CHECK_EN macro.
package bcd_pkg;

   localparam int         DIGIT_W  = 4;
   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_CORR = 4'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// Combinational single-digit BCD adder with decimal correction.
// The invalid output only has comparators behind it when BCD_ERR_CHECK_EN is defined.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] a_d,
   input  logic [DIGIT_W-1:0] b_d,
   input  logic               c_in,
   output logic [DIGIT_W-1:0] digit,
   output logic               c_out,
   output logic               invalid
);

   logic [DIGIT_W:0] sum_raw;

   always_comb begin
      sum_raw = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, c_in};
      digit   = sum_raw[DIGIT_W-1:0];
      c_out   = 1'b0;
      // Adding 6 modulo 16 skips the six unused codes and yields the low decimal digit.
      if (sum_raw > {1'b0, BCD_MAX}) begin
         digit = sum_raw[DIGIT_W-1:0] + BCD_CORR;
         c_out = 1'b1;
      end
   end

`ifdef BCD_ERR_CHECK_EN
   assign invalid = (a_d > BCD_MAX) || (b_d > BCD_MAX);
`else
   assign invalid = 1'b0;
`endif

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared digit adder, one digit per clock, LSD first.
// Invalid-digit reporting on err is built only when BCD_ERR_CHECK_EN is defined.
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [DIGIT_W*DIGITS-1:0] a,
   input  logic [DIGIT_W*DIGITS-1:0] b,
   input  logic                      cin,
   output logic                      busy,
   output logic                      done,
   output logic [DIGIT_W*DIGITS-1:0] sum,
   output logic                      cout,
   output logic                      err
);

   localparam int W     = DIGIT_W * DIGITS;
   localparam int IDX_W = $clog2(DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     opa_q, opa_d;
   logic [W-1:0]     opb_q, opb_d;
   logic [W-1:0]     wsum_q, wsum_d;
   logic             werr_q, werr_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             err_q, err_d;

   logic [DIGIT_W-1:0] a_dig [DIGITS];
   logic [DIGIT_W-1:0] b_dig [DIGITS];
   logic [DIGIT_W-1:0] dig_a, dig_b, dig_sum;
   logic               dig_cout, dig_inv;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign a_dig[gi] = opa_q[gi*DIGIT_W +: DIGIT_W];
         assign b_dig[gi] = opb_q[gi*DIGIT_W +: DIGIT_W];
         // Only the slot addressed by the index takes the new digit.
         assign wsum_d[gi*DIGIT_W +: DIGIT_W] =
            (state_q == ADD && idx_q == IDX_W'(gi)) ? dig_sum
                                                    : wsum_q[gi*DIGIT_W +: DIGIT_W];
      end
   endgenerate

   assign dig_a = a_dig[idx_q];
   assign dig_b = b_dig[idx_q];

   bcd_digit_add u_digit_add (
      .a_d     (dig_a),
      .b_d     (dig_b),
      .c_in    (carry_q),
      .digit   (dig_sum),
      .c_out   (dig_cout),
      .invalid (dig_inv)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      werr_d  = werr_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = b;
               carry_d = cin;
               idx_d   = '0;
               werr_d  = 1'b0;
               state_d = ADD;
            end
         end
         ADD: begin
            carry_d = dig_cout;
            werr_d  = werr_q | dig_inv;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               // Results are published together with the final digit so they appear with done.
               idx_d   = '0;
               sum_d   = wsum_d;
               cout_d  = dig_cout;
               err_d   = werr_q | dig_inv;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         wsum_q  <= '0;
         werr_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         wsum_q  <= wsum_d;
         werr_q  <= werr_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
      end
   end

   assign busy = (state_q == ADD);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Randomized bench for bcd_serial_add_ctrl against a decimal-arithmetic reference model.
// Expects err only when built with BCD_ERR_CHECK_EN defined.
module tb_bcd_serial_add_ctrl;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;
`ifdef BCD_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout, err;
   logic [W-1:0] sum;

   int n_vec = 0;
   int n_err = 0;

   bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit has_invalid(input logic [W-1:0] x);
      logic [3:0] d;
      for (int i = 0; i < DIGITS; i++) begin
         d = x[4*i +: 4];
         if (d > 4'd9) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Valid operands: plain decimal integer addition. Invalid digits: the stated per-digit rule.
   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
      longint tx = 0, ty = 0, tot, lim = 1;
      logic [W-1:0] r = '0;
      logic [3:0] dx, dy;
      logic co;
      int s, cy;
      if (!has_invalid(x) && !has_invalid(y)) begin
         for (int i = DIGITS - 1; i >= 0; i--) begin
            dx = x[4*i +: 4];
            dy = y[4*i +: 4];
            tx = tx * 10 + longint'(dx);
            ty = ty * 10 + longint'(dy);
            lim = lim * 10;
         end
         tot = tx + ty + longint'(c);
         co  = (tot >= lim);
         if (co) tot = tot - lim;
         for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(tot % 10);
            tot = tot / 10;
         end
         return {co, r};
      end
      cy = int'(c);
      for (int i = 0; i < DIGITS; i++) begin
         dx = x[4*i +: 4];
         dy = y[4*i +: 4];
         s = int'(dx) + int'(dy) + cy;
         if (s > 9) begin
            r[4*i +: 4] = 4'((s + 6) % 16);
            cy = 1;
         end else begin
            r[4*i +: 4] = 4'(s);
            cy = 0;
         end
      end
      return {cy[0], r};
   endfunction

   // Model: a countdown of cycles remaining since the accepted request.
   int           m_cnt = 0;
   logic [W:0]   m_pend = '0;
   logic         m_pend_err = 1'b0;
   logic [W-1:0] e_sum = '0;
   logic         e_cout = 1'b0;
   logic         e_err = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         e_sum  <= '0;
         e_cout <= 1'b0;
         e_err  <= 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 2) begin
            e_sum  <= m_pend[W-1:0];
            e_cout <= m_pend[W];
            e_err  <= m_pend_err;
         end
      end else if (start) begin
         m_cnt      <= DIGITS + 1;
         m_pend     <= ref_add(a, b, cin);
         m_pend_err <= ERR_EN && (has_invalid(a) || has_invalid(b));
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", 32'(busy), 32'(m_cnt >= 2));
         chk("done", 32'(done), 32'(m_cnt == 1));
         chk("sum",  32'(sum),  32'(e_sum));
         chk("cout", 32'(cout), 32'(e_cout));
         chk("err",  32'(err),  32'(e_err));
      end
   end

   // Caller must be at a negedge in an IDLE cycle; returns at the negedge of the done cycle.
   task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        output int latency, output int busy_cycles);
      a = xa; b = xb; cin = xc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      latency = 1;
      busy_cycles = 0;
      while (!done && latency < 20) begin
         if (busy) busy_cycles++;
         @(negedge clk);
         latency++;
      end
   endtask

   task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xc, input logic [W-1:0] xs, input logic xco,
                         input logic xe);
      int lat, bc;
      issue(xa, xb, xc, lat, bc);
      $display("op %s: a=%h b=%h cin=%0d -> sum=%h cout=%0d err=%0d latency=%0d",
               name, xa, xb, xc, sum, cout, err, lat);
      chk({name, "_latency"}, 32'(lat), 32'(DIGITS + 1));
      chk({name, "_busy_cycles"}, 32'(bc), 32'(DIGITS));
      chk({name, "_sum"}, 32'(sum), 32'(xs));
      chk({name, "_cout"}, 32'(cout), 32'(xco));
      chk({name, "_err"}, 32'(err), 32'(xe));
      chk({name, "_model_sum"}, 32'(e_sum), 32'(xs));
      chk({name, "_model_cout"}, 32'(e_cout), 32'(xco));
      @(negedge clk);
   endtask

   initial begin
      int lat, bc, n_done;
      logic [W-1:0] ra, rb, got_sum;
      logic got_cout;

      #12;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_sum",  32'(sum),  32'd0);
      chk("reset_cout", 32'(cout), 32'd0);
      chk("reset_err",  32'(err),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("ripple",  16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("cin_all", 16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_op("nocarry", 16'h0042, 16'h0035, 1'b0, 16'h0077, 1'b0, 1'b0);
      run_op("carry1",  16'h0009, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0);
      run_op("invalid", 16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, ERR_EN);
      run_op("clr_err", 16'h0123, 16'h0456, 1'b0, 16'h0579, 1'b0, 1'b0);

      // Start re-pulsed two cycles after accept must be ignored.
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'h5555; b = 16'h4444; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_done = 0;
      got_sum = '0;
      got_cout = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            n_done++;
            got_sum = sum;
            got_cout = cout;
         end
         @(negedge clk);
      end
      $display("op ignore_start: dones=%0d sum=%h cout=%0d", n_done, got_sum, got_cout);
      chk("ignore_start_dones", 32'(n_done), 32'd1);
      chk("ignore_start_sum", 32'(got_sum), 32'h3333);
      chk("ignore_start_cout", 32'(got_cout), 32'd0);

      // Reset during the second ADD cycle.
      a = 16'h1234; b = 16'h1234; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      $display("op reset_mid: busy=%0d done=%0d sum=%h cout=%0d", busy, done, sum, cout);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_done", 32'(done), 32'd0);
      chk("rstmid_sum",  32'(sum),  32'd0);
      chk("rstmid_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("after_rst", 16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0);

      // Random operations with idle gaps; ~1 in 8 uses raw 4-bit digits.
      for (int n = 0; n < 40; n++) begin
         ra = '0;
         rb = '0;
         for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(7) == 0) begin
               ra[4*i +: 4] = 4'($urandom_range(15));
               rb[4*i +: 4] = 4'($urandom_range(15));
            end else begin
               ra[4*i +: 4] = 4'($urandom_range(9));
               rb[4*i +: 4] = 4'($urandom_range(9));
            end
         end
         issue(ra, rb, 1'($urandom_range(1)), lat, bc);
         $display("op rand%0d: a=%h b=%h cin=%0d -> sum=%h cout=%0d err=%0d",
                  n, ra, rb, cin, sum, cout, err);
         chk("rand_latency", 32'(lat), 32'(DIGITS + 1));
         repeat ($urandom_range(3) + 1) @(negedge clk);
      end

      // Start held high with operands changing every cycle.
      n_done = 0;
      start = 1'b1;
      for (int i = 0; i < 3 * (DIGITS + 2); i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         cin = 1'($urandom_range(1));
         @(negedge clk);
         if (done) n_done++;
      end
      start = 1'b0;
      $display("op held_start: dones=%0d", n_done);
      chk("held_start_dones", 32'(n_done), 32'd3);
      repeat (DIGITS + 4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Digit-serial controller that adds two multi-digit packed-BCD operands by time-sharing one single-digit BCD adder. It processes one digit per clock, least-significant first, and rippling the decimal carry through a register. It sits between a requesting unit (start/done handshake) and the single-digit BCD correction datapath, trading latency for area versus a fully parallel N-digit adder chain.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand; legal range 2..16.
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: asynchronous active-low reset.
- `start` input, 1: request pulse; accepted only in IDLE.
- `a` input, 4*DIGITS: packed BCD operand A; digit i is `a[4i+3:4i]`.
- `b` input, 4*DIGITS: packed BCD operand B.
- `cin` input, 1: decimal carry-in to digit 0.
- `busy` output, 1: high while digits are being processed.
- `done` output, 1: single-cycle pulse when the result is valid.
- `sum` output, 4*DIGITS: packed BCD result; holds the last result.
- `cout` output, 1: decimal carry out of the top digit.
- `err` output, 1: invalid-digit flag; see Configuration.

## Operation
- The FSM has three states: IDLE, ADD and DONE.
- **IDLE**, when `start`=1:
  - Latch `a`, `b` and `cin` into working registers.
  - Clear the digit index and the working err flag.
  - Go to ADD.
- **IDLE**, when `start`=0: remain in IDLE.
- **ADD**, each cycle, for digit at index `idx`:
  - Compute s = a_d + b_d + carry as 5 bits, range 0..19.
  - If s > 9: digit = (s+6)[3:0] and carry = 1. Otherwise digit = s[3:0] and carry = 0.
  - Write the digit into working-sum slot `idx`, then increment `idx`.
  - When `idx` == DIGITS-1, go to DONE.
- **DONE**, for exactly one cycle:
  - `done`=1.
  - `sum`, `cout` and `err` are loaded from the working registers on entry to DONE.
  - Return to IDLE.
- `start` is ignored in ADD and DONE. It has no queueing, and operands may change freely after the accept edge.
- `sum`, `cout` and `err` change only on entry to DONE. They are stable from then until the next completed operation.
- `busy` = (state == ADD).

## Timing
- `start` is sampled high at edge k.
- `busy` is high for cycles k+1 through k+DIGITS.
- `done` is high for cycle k+DIGITS+1, and `sum`/`cout`/`err` are valid from that cycle.
- Total latency is DIGITS+1 cycles. Maximum throughput is one operation per DIGITS+2 cycles, since `start` can next be accepted in the IDLE cycle after DONE.
- Reset values: state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, `err`=0, and the working registers are 0.
- Reset asserted mid-operation aborts immediately. No `done` is issued, and `sum` returns to 0.
- `start` held high continuously: a new operation is accepted in each IDLE cycle, i.e. every DIGITS+2 cycles.

## Configuration
- Macro `BCD_ERR_CHECK_EN`.
- **Defined:**
  - In each ADD cycle, if a_d > 9 or b_d > 9, the working err flag is set.
  - The flag is sticky for the operation and is presented on `err` with `done`.
  - The result is still computed with the same correction rule and is undefined as decimal.
- **Undefined:**
  - `err` is tied to 0 and no comparators are built.
  - Invalid digits pass through the correction rule silently.

## Structure
- Package `bcd_pkg` contains:
  - the state typedef (IDLE/ADD/DONE);
  - `BCD_MAX` = 9;
  - `BCD_CORR` = 6;
  - the digit width constant = 4.
- Sub-module `bcd_digit_add` is a combinational single-digit adder:
  - inputs: a_d, b_d, c_in;
  - outputs: digit, c_out, and invalid.
- The controller instantiates one `bcd_digit_add` and holds the FSM, the index counter, the carry register and the working registers.

## Test plan
- **Basic carry ripple.** DIGITS=4, a=0x1234, b=0x8766, cin=0, start pulse → `done` in cycle 5 after accept, `sum`=0x0000, `cout`=1, `busy` high 4 cycles.
- **Carry-in through all digits.** a=0x9999, b=0x0000, cin=1 → `sum`=0x0000, `cout`=1.
- **No-carry case.** a=0x0042, b=0x0035, cin=0 → `sum`=0x0077, `cout`=0. Then a=0x0009, b=0x0001 → `sum`=0x0010, `cout`=0.
- **Start ignored while busy.** Pulse `start` with new operands 2 cycles after accept → only one `done`, and the result matches the first operands.
- **Reset mid-operation.** Drop `rst_n` in the 2nd ADD cycle → `busy`, `done`, `sum` and `cout` go to 0 immediately. After release, a fresh operation of 0x0500+0x0500 gives `sum`=0x1000, `cout`=0.
- **Error flag (`BCD_ERR_CHECK_EN` defined).** a=0x00A0, b=0x0001 → `err`=1 with `done`. The next valid operation clears `err` to 0.
